dispatch_buffer: RTL and testbench

- Small in-order FIFO between rename/dispatch and the issue queue.
- Accepts one renamed instruction per cycle from rename through a valid/ready handshake.
- Presents the oldest buffered instruction to the issue queue using the queue_inst_valid / queue_full pair.
- Isolates rename from issue-queue backpressure and drops all buffered work on a pipeline flush.

---
 rtl/dispatch_buffer_pkg.sv | 25 ++
 rtl/dispatch_buffer_if.sv | 46 ++++
 rtl/dispatch_buffer.sv | 124 ++++++++++++
 tb/tb_dispatch_buffer.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/dispatch_buffer_pkg.sv
// -----------------------------------------------------------------------------
// dispatch_pkg
// Shared types and constants for the dispatch buffer and the issue queue.
//   dispatch_entry_t : one renamed instruction as it travels from rename to issue.
//   PTR_W / CNT_W    : head/tail pointer width and occupancy-count width for DEPTH.
// -----------------------------------------------------------------------------
package dispatch_pkg;

    localparam int unsigned INST_ID_BITS = 6;
    localparam int unsigned PRN_BITS     = 6;
    localparam int unsigned MAX_OPERANDS = 3;
    localparam int unsigned DEPTH        = 4;  // power of two, >= 2

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [INST_ID_BITS-1:0]                 inst_id;
        logic [31:0]                             inst;
        logic [MAX_OPERANDS-1:0][63:0]           op;
        logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]   out_prn;
        logic [63:0]                             pc;
    } dispatch_entry_t;

endpackage

// File: rtl/dispatch_buffer_if.sv
// -----------------------------------------------------------------------------
// dispatch_buffer_if
// Bundles the rename-side handshake, the issue-queue-side handshake, flush and
// occupancy of the dispatch buffer.
//   slave  : the buffer's view (consumes in_*, flush, queue_full; drives the rest)
//   master : the surrounding pipeline's view (rename, issue queue, flush source)
// Signals:
//   flush, in_valid/in_ready, in_inst_id, in_inst, in_op, in_out_prn, in_pc,
//   queue_inst_valid/queue_full, inst_id, inst, op, out_prn, pc, count
// -----------------------------------------------------------------------------
interface dispatch_buffer_if #(
    parameter int unsigned DEPTH = dispatch_pkg::DEPTH
);
    import dispatch_pkg::*;

    logic                                  flush;

    logic                                  in_valid;
    logic                                  in_ready;
    logic [INST_ID_BITS-1:0]               in_inst_id;
    logic [31:0]                           in_inst;
    logic [MAX_OPERANDS-1:0][63:0]         in_op;
    logic [MAX_OPERANDS-1:0][PRN_BITS-1:0] in_out_prn;
    logic [63:0]                           in_pc;

    logic                                  queue_inst_valid;
    logic                                  queue_full;
    logic [INST_ID_BITS-1:0]               inst_id;
    logic [31:0]                           inst;
    logic [MAX_OPERANDS-1:0][63:0]         op;
    logic [MAX_OPERANDS-1:0][PRN_BITS-1:0] out_prn;
    logic [63:0]                           pc;

    logic [$clog2(DEPTH+1)-1:0]            count;

    modport slave (
        input  flush, in_valid, in_inst_id, in_inst, in_op, in_out_prn, in_pc, queue_full,
        output in_ready, queue_inst_valid, inst_id, inst, op, out_prn, pc, count
    );

    modport master (
        output flush, in_valid, in_inst_id, in_inst, in_op, in_out_prn, in_pc, queue_full,
        input  in_ready, queue_inst_valid, inst_id, inst, op, out_prn, pc, count
    );

endinterface

// File: rtl/dispatch_buffer.sv
// -----------------------------------------------------------------------------
// dispatch_buffer
// In-order FIFO between rename/dispatch and the issue queue. Accepts one
// instruction per cycle (in_valid/in_ready), offers the oldest entry to the
// issue queue (queue_inst_valid means it is taken this cycle unless queue_full),
// and discards everything on flush.
// Ports:
//   clk  : clock
//   rst  : asynchronous active-low reset
//   bus  : dispatch_buffer_if.slave (handshakes, payloads, flush, count)
// Build option:
//   DISPATCH_BUFFER_BYPASS_EN : when defined, an instruction arriving at an
//   empty buffer with the issue queue ready is forwarded in the same cycle
//   without being written.
// -----------------------------------------------------------------------------
module dispatch_buffer
    import dispatch_pkg::*;
#(
    parameter int unsigned DEPTH = dispatch_pkg::DEPTH  // power of two, >= 2
) (
    input  logic               clk,
    input  logic               rst,
    dispatch_buffer_if.slave   bus
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam logic [CntW-1:0] CountFull = CntW'(DEPTH);

    dispatch_entry_t mem_q [DEPTH];

    logic [PtrW-1:0] head_q, head_d;
    logic [PtrW-1:0] tail_q, tail_d;
    logic [CntW-1:0] count_q, count_d;

    dispatch_entry_t in_entry;
    dispatch_entry_t out_entry;
    logic            push;
    logic            pop;
    logic            bypass;
    logic            in_ready;

    always_comb begin
        in_entry         = '0;
        in_entry.inst_id = bus.in_inst_id;
        in_entry.inst    = bus.in_inst;
        in_entry.op      = bus.in_op;
        in_entry.out_prn = bus.in_out_prn;
        in_entry.pc      = bus.in_pc;
    end

`ifdef DISPATCH_BUFFER_BYPASS_EN
    // Empty buffer and a ready issue queue: hand the input straight through.
    always_comb begin
        bypass = rst && (count_q == '0) && bus.in_valid && !bus.queue_full && !bus.flush;
    end
`else
    always_comb begin
        bypass = 1'b0;
    end
`endif

    always_comb begin
        // Depends only on local state so queue_full never reaches in_ready.
        in_ready = rst && (count_q != CountFull);
        push     = bus.in_valid && in_ready && !bus.flush && !bypass;
        pop      = rst && (count_q != '0) && !bus.queue_full && !bus.flush;
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (bus.flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) begin
                tail_d = tail_q + PtrW'(1);
            end
            if (pop) begin
                head_d = head_q + PtrW'(1);
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + CntW'(1);
                2'b01:   count_d = count_q - CntW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload storage is intentionally left unreset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[tail_q] <= in_entry;
        end
    end

    always_comb begin
        out_entry            = bypass ? in_entry : mem_q[head_q];
        bus.in_ready         = in_ready;
        bus.queue_inst_valid = pop || bypass;
        bus.inst_id          = out_entry.inst_id;
        bus.inst             = out_entry.inst;
        bus.op               = out_entry.op;
        bus.out_prn          = out_entry.out_prn;
        bus.pc               = out_entry.pc;
        bus.count            = count_q;
    end

endmodule

// File: tb/tb_dispatch_buffer.sv
// -----------------------------------------------------------------------------
// tb_dispatch_buffer
// Self-checking bench for dispatch_buffer: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
// -----------------------------------------------------------------------------
module tb_dispatch_buffer;
    import dispatch_pkg::*;

`ifdef DISPATCH_BUFFER_BYPASS_EN
    localparam bit Bypass = 1'b1;
`else
    localparam bit Bypass = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    dispatch_buffer_if #(.DEPTH(DEPTH)) bus ();

    dispatch_buffer #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int unsigned     n_total = 0;
    int unsigned     n_bad   = 0;
    dispatch_entry_t model_q[$];
    dispatch_entry_t cur;
    logic            last_acc;
    logic [INST_ID_BITS-1:0] next_id = 6'd40;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic dispatch_entry_t make_entry(input logic [INST_ID_BITS-1:0] id);
        dispatch_entry_t e;
        e.inst_id = id;
        e.inst    = $urandom;
        for (int k = 0; k < MAX_OPERANDS; k++) begin
            e.op[k]      = {$urandom, $urandom};
            e.out_prn[k] = PRN_BITS'($urandom);
        end
        e.pc = 64'h8000_0000 + 64'(id) * 4 + {32'h0, $urandom} * 64'h100;
        return e;
    endfunction

    task automatic drive(input logic valid, input dispatch_entry_t e);
        cur            = e;
        bus.in_valid   = valid;
        bus.in_inst_id = e.inst_id;
        bus.in_inst    = e.inst;
        bus.in_op      = e.op;
        bus.in_out_prn = e.out_prn;
        bus.in_pc      = e.pc;
    endtask

    // One clock: check outputs mid-cycle against the model, then advance the model.
    task automatic cycle();
        int              sz;
        logic            byp, exp_ready, exp_valid, push, pop, fl;
        dispatch_entry_t exp_head;
        @(negedge clk);
        sz        = model_q.size();
        fl        = bus.flush;
        byp       = Bypass && sz == 0 && bus.in_valid && !bus.queue_full && !fl;
        exp_ready = (sz != int'(DEPTH));
        exp_valid = (sz != 0 && !bus.queue_full && !fl) || byp;
        check_eq("in_ready", 64'(bus.in_ready), 64'(exp_ready));
        check_eq("queue_inst_valid", 64'(bus.queue_inst_valid), 64'(exp_valid));
        check_eq("count", 64'(bus.count), 64'(sz));
        if (exp_valid) begin
            exp_head = byp ? cur : model_q[0];
            check_eq("inst_id", 64'(bus.inst_id), 64'(exp_head.inst_id));
            check_eq("inst", 64'(bus.inst), 64'(exp_head.inst));
            check_eq("pc", bus.pc, exp_head.pc);
            check_eq("out_prn", 64'(bus.out_prn), 64'(exp_head.out_prn));
            for (int k = 0; k < MAX_OPERANDS; k++) begin
                check_eq("op", bus.op[k], exp_head.op[k]);
            end
        end
        push = bus.in_valid && exp_ready && !fl && !byp;
        pop  = exp_valid && !byp;
        @(posedge clk);
        if (fl) begin
            model_q.delete();
        end else begin
            if (pop) void'(model_q.pop_front());
            if (push) model_q.push_back(cur);
        end
        last_acc = push || byp;
        #1;
    endtask

    initial begin
        bus.flush      = 1'b0;
        bus.queue_full = 1'b0;
        drive(1'b0, make_entry(6'd0));

        // Reset held: interface must be closed.
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_in_ready", 64'(bus.in_ready), 64'd0);
        check_eq("rst_valid", 64'(bus.queue_inst_valid), 64'd0);
        check_eq("rst_count", 64'(bus.count), 64'd0);
        rst = 1'b1;
        cycle();
        check_eq("idle_in_ready", 64'(bus.in_ready), 64'd1);

        // IDs 1,2,3 back to back with the issue queue open.
        for (int id = 1; id <= 3; id++) begin
            drive(1'b1, make_entry(INST_ID_BITS'(id)));
            cycle();
            check_eq("stream_count", 64'(bus.count), Bypass ? 64'd0 : 64'd1);
        end
        drive(1'b0, cur);
        repeat (2) cycle();

        // Five pushes against a stalled issue queue; the fifth must wait.
        bus.queue_full = 1'b1;
        begin
            int i = 0;
            drive(1'b1, make_entry(6'd10));
            repeat (6) begin
                cycle();
                if (last_acc) begin
                    i++;
                    drive(1'b1, make_entry(INST_ID_BITS'(10 + i)));
                end
            end
            check_eq("full_accepted", 64'(i), 64'd4);
        end
        check_eq("full_count", 64'(bus.count), 64'd4);
        check_eq("full_in_ready", 64'(bus.in_ready), 64'd0);
        // Release: pop frees a slot, the held fifth goes in on the following cycle.
        bus.queue_full = 1'b0;
        cycle();
        check_eq("release_count", 64'(bus.count), 64'd3);
        cycle();
        check_eq("refill_count", 64'(bus.count), 64'd3);
        drive(1'b0, cur);
        repeat (5) cycle();
        check_eq("drained_count", 64'(bus.count), 64'd0);

        // Flush with three entries and a concurrent push.
        bus.queue_full = 1'b1;
        for (int id = 20; id < 23; id++) begin
            drive(1'b1, make_entry(INST_ID_BITS'(id)));
            cycle();
        end
        drive(1'b1, make_entry(6'd23));
        bus.flush = 1'b1;
        cycle();
        bus.flush      = 1'b0;
        bus.queue_full = 1'b0;
        drive(1'b0, cur);
        check_eq("flush_count", 64'(bus.count), 64'd0);
        check_eq("flush_valid", 64'(bus.queue_inst_valid), 64'd0);
        repeat (3) cycle();

`ifdef DISPATCH_BUFFER_BYPASS_EN
        // Zero-latency forward into an empty buffer.
        drive(1'b1, make_entry(6'd7));
        #1;
        check_eq("byp_valid", 64'(bus.queue_inst_valid), 64'd1);
        check_eq("byp_inst_id", 64'(bus.inst_id), 64'd7);
        check_eq("byp_count", 64'(bus.count), 64'd0);
        cycle();
        check_eq("byp_count_after", 64'(bus.count), 64'd0);
        drive(1'b0, cur);
`endif

        // Asynchronous reset mid-operation.
        bus.queue_full = 1'b1;
        for (int id = 30; id < 32; id++) begin
            drive(1'b1, make_entry(INST_ID_BITS'(id)));
            cycle();
        end
        drive(1'b0, cur);
        #2 rst = 1'b0;
        #1;
        check_eq("midrst_count", 64'(bus.count), 64'd0);
        check_eq("midrst_in_ready", 64'(bus.in_ready), 64'd0);
        check_eq("midrst_valid", 64'(bus.queue_inst_valid), 64'd0);
        model_q.delete();
        @(posedge clk);
        #1 rst = 1'b1;
        cycle();

        // Random traffic; rename holds an instruction until it is accepted.
        last_acc = 1'b1;
        repeat (1500) begin
            if (last_acc || !bus.in_valid) begin
                drive(($urandom % 4) != 0, make_entry(next_id));
                next_id++;
            end
            bus.queue_full = ($urandom % 3) == 0;
            bus.flush      = ($urandom % 40) == 0;
            cycle();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
